// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key input path.
//   - state_t: gesture classifier state encoding.
//   - Default timing constants for a 12 MHz system clock, used as parameter
//     defaults by the classifier and its release filter.
//   - The debouncer's settle delay lives here too, so every block on the key
//     path derives its timing from one place.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESSED = 3'd1,
    HELD    = 3'd2,
    WAIT2   = 3'd3,
    SECOND  = 3'd4
  } state_t;

  localparam int DEF_CNT_W        = 24;
  localparam int DEF_LONG_CYC     = 12_000_000;  // 1 s
  localparam int DEF_DBL_CYC      = 3_600_000;   // 300 ms
  localparam int DEF_REL_CYC      = 240_000;     // 20 ms
  localparam int DEF_REP_CYC      = 2_400_000;   // 200 ms
  localparam int DEF_DEBOUNCE_CYC = 240_000;     // 20 ms debouncer settle time

endpackage

// File: rtl/key_release_filter.sv
// key_release_filter: release qualifier for one key.
//   Synchronises the raw active-low key level and asserts rel_ok once the
//   synchronised level has been high (released) for REL_CYC consecutive cycles.
//   Any low sample restarts the run.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous, active-high reset
//   key_n  in  raw key level, 0 = pressed, asynchronous to clk
//   rel_ok out high while the release has been stable for >= REL_CYC cycles
module key_release_filter
  import key_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int REL_CYC = DEF_REL_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic rel_ok
);

  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYC);

  logic             key_meta;
  logic             key_sync;
  logic [CNT_W-1:0] run;

  // Run counter saturates at REL_CYC, so rel_ok holds for as long as the key
  // stays released.
  assign rel_ok = (run == REL_LAST);

  // Both synchroniser flops reset to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      run      <= '0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      if (!key_sync) begin
        run <= '0;
      end else if (!rel_ok) begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_press_classifier.sv
// key_press_classifier: gesture classifier for a single debounced key.
//   Turns the debouncer's press strobe plus the raw key level into one-cycle
//   event strobes: short click, double click, long press and auto-repeat while
//   a long press is held. busy is high whenever a gesture is in progress.
// Ports:
//   clk          in  system clock (12 MHz nominal)
//   rst          in  asynchronous, active-high reset
//   press_pulse  in  one-cycle debounced press strobe
//   key_n        in  raw key level, 0 = pressed, asynchronous to clk
//   short_pulse  out one cycle: single short click confirmed
//   double_pulse out one cycle: second press inside the double-click window
//   long_pulse   out one cycle: key held LONG_CYC cycles
//   repeat_pulse out one cycle every REP_CYC while held after long_pulse
//   busy         out high whenever the classifier is not idle
// The debouncer only emits press_pulse after the key has been low for its
// settle time, so the synchronised level is already low (rel_ok clear) by the
// time a press is accepted.
module key_press_classifier
  import key_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter int DBL_CYC  = DEF_DBL_CYC,
  parameter int REL_CYC  = DEF_REL_CYC,
  parameter int REP_CYC  = DEF_REP_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic press_pulse,
  input  logic key_n,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rel_ok;
  logic             short_nxt;
  logic             double_nxt;
  logic             long_nxt;
  logic             repeat_nxt;

  key_release_filter #(
    .CNT_W  (CNT_W),
    .REL_CYC(REL_CYC)
  ) u_release (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .rel_ok(rel_ok)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_pulse  <= short_nxt;
      double_pulse <= double_nxt;
      long_pulse   <= long_nxt;
      repeat_pulse <= repeat_nxt;
    end
  end

  // Each branch checks its exit condition before its terminal count, which
  // gives release priority over long press / repeat and a second press
  // priority over the double-click timeout.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (press_pulse) begin
          state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (rel_ok) begin
          state_nxt = WAIT2;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (rel_ok) begin
          state_nxt = IDLE;
        end else if (cnt == REP_LAST) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end
      end
      WAIT2: begin
        if (press_pulse) begin
          double_nxt = 1'b1;
          state_nxt  = SECOND;
        end else if (cnt == DBL_LAST) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      SECOND: begin
        // Nothing is timed on the second press; just wait for its release.
        cnt_nxt = '0;
        if (rel_ok) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Every state starts timing from zero.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// tb_key_press_classifier: directed bench for key_press_classifier with short
// timing parameters. All times are expressed as rising-edge counts (cyc);
// p0 is the edge that accepts the first press. A release driven just after
// edge R is seen as rel_ok after edge R+2+REL (two synchroniser stages, then
// REL counted high samples).
module tb_key_press_classifier;

  localparam int LONG = 100;
  localparam int DBL  = 40;
  localparam int REL  = 5;
  localparam int REP  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic press_pulse = 1'b0;
  logic key_n = 1'b1;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int n_short, n_double, n_long, n_repeat, n_multi;
  int t_short, t_double, t_long;
  int t_rep[$];

  key_press_classifier #(
    .CNT_W   (24),
    .LONG_CYC(LONG),
    .DBL_CYC (DBL),
    .REL_CYC (REL),
    .REP_CYC (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .press_pulse (press_pulse),
    .key_n       (key_n),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if ((int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse)) > 1) n_multi++;
      if (short_pulse)  begin n_short++;  t_short  = cyc; end
      if (double_pulse) begin n_double++; t_double = cyc; end
      if (long_pulse)   begin n_long++;   t_long   = cyc; end
      if (repeat_pulse) begin n_repeat++; t_rep.push_back(cyc); end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mon();
    n_short = 0; n_double = 0; n_long = 0; n_repeat = 0; n_multi = 0;
    t_short = -1; t_double = -1; t_long = -1;
    t_rep.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // Key goes low, the debouncer strobe follows a few cycles later.
  task automatic press(output int p0);
    key_n = 1'b0;
    tick(4);
    press_pulse = 1'b1;
    tick(1);
    press_pulse = 1'b0;
    p0 = cyc;
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== 5'b0) begin failures++; $display("FAIL reset_outputs: got %b want 00000", {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}); end
    rst = 1'b0;
    tick(10);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_short();
    int p0, r;
    clear_mon();
    press(p0);
    wait_until(p0 + 30);
    key_n = 1'b1;
    r = p0 + 30 + 2 + REL;
    wait_until(r + 10);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL short_busy_wait2: got %b want 1", busy); end
    wait_until(r + DBL + 20);
    checks++; if (n_short !== 1) begin failures++; $display("FAIL short_count: got %0d want 1", n_short); end
    checks++; if (t_short !== r + 1 + DBL) begin failures++; $display("FAIL short_time: got %0d want %0d", t_short, r + 1 + DBL); end
    checks++; if (n_double + n_long + n_repeat !== 0) begin failures++; $display("FAIL short_other_strobes: got %0d want 0", n_double + n_long + n_repeat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_double();
    int p0, r;
    clear_mon();
    press(p0);
    wait_until(p0 + 30);
    key_n = 1'b1;
    r = p0 + 30 + 2 + REL;
    wait_until(r + 15);
    key_n = 1'b0;
    wait_until(r + 19);
    press_pulse = 1'b1;
    tick(1);
    press_pulse = 1'b0;
    checks++; if (double_pulse !== 1'b1) begin failures++; $display("FAIL double_strobe: got %b want 1", double_pulse); end
    wait_until(r + 30);
    key_n = 1'b1;
    wait_until(r + 37);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL double_busy_second: got %b want 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL double_busy_drop: got %b want 0", busy); end
    wait_until(r + 100);
    checks++; if (n_double !== 1) begin failures++; $display("FAIL double_count: got %0d want 1", n_double); end
    checks++; if (t_double !== r + 20) begin failures++; $display("FAIL double_time: got %0d want %0d", t_double, r + 20); end
    checks++; if (n_short + n_long + n_repeat !== 0) begin failures++; $display("FAIL double_other_strobes: got %0d want 0", n_short + n_long + n_repeat); end
  endtask

  task automatic test_long();
    int p0, rep0, rep1;
    clear_mon();
    press(p0);
    wait_until(p0 + 150);
    key_n = 1'b1;
    wait_until(p0 + 200);
    rep0 = (t_rep.size() > 0) ? t_rep[0] : -1;
    rep1 = (t_rep.size() > 1) ? t_rep[1] : -1;
    checks++; if (n_long !== 1) begin failures++; $display("FAIL long_count: got %0d want 1", n_long); end
    checks++; if (t_long !== p0 + LONG) begin failures++; $display("FAIL long_time: got %0d want %0d", t_long, p0 + LONG); end
    checks++; if (n_repeat !== 2) begin failures++; $display("FAIL repeat_count: got %0d want 2", n_repeat); end
    checks++; if (rep0 !== p0 + LONG + REP) begin failures++; $display("FAIL repeat0_time: got %0d want %0d", rep0, p0 + LONG + REP); end
    checks++; if (rep1 !== p0 + LONG + 2 * REP) begin failures++; $display("FAIL repeat1_time: got %0d want %0d", rep1, p0 + LONG + 2 * REP); end
    checks++; if (n_short + n_double !== 0) begin failures++; $display("FAIL long_other_strobes: got %0d want 0", n_short + n_double); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL long_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    int p0;
    clear_mon();
    press(p0);
    wait_until(p0 + 20);
    key_n = 1'b1;
    wait_until(p0 + 23);
    key_n = 1'b0;
    wait_until(p0 + 105);
    key_n = 1'b1;
    wait_until(p0 + 150);
    checks++; if (n_long !== 1) begin failures++; $display("FAIL glitch_long_count: got %0d want 1", n_long); end
    checks++; if (t_long !== p0 + LONG) begin failures++; $display("FAIL glitch_long_time: got %0d want %0d", t_long, p0 + LONG); end
    checks++; if (n_short + n_double + n_repeat !== 0) begin failures++; $display("FAIL glitch_other_strobes: got %0d want 0", n_short + n_double + n_repeat); end
  endtask

  task automatic test_reset_mid();
    int p0, r;
    // Reset while waiting for a second press.
    clear_mon();
    press(p0);
    wait_until(p0 + 30);
    key_n = 1'b1;
    r = p0 + 30 + 2 + REL;
    wait_until(r + 10);
    rst = 1'b1;
    #1;
    checks++; if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== 5'b0) begin failures++; $display("FAIL rst_wait2_outputs: got %b want 00000", {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}); end
    tick(2);
    rst = 1'b0;
    wait_until(r + 80);
    checks++; if (n_short !== 0) begin failures++; $display("FAIL rst_wait2_no_short: got %0d want 0", n_short); end
    // Reset on the very cycle a repeat strobe is showing.
    clear_mon();
    press(p0);
    wait_until(p0 + LONG + REP);
    checks++; if (repeat_pulse !== 1'b1) begin failures++; $display("FAIL rst_held_pre_repeat: got %b want 1", repeat_pulse); end
    rst = 1'b1;
    #1;
    checks++; if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== 5'b0) begin failures++; $display("FAIL rst_held_outputs: got %b want 00000", {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}); end
    key_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    // Normal short click afterwards.
    clear_mon();
    press(p0);
    wait_until(p0 + 30);
    key_n = 1'b1;
    wait_until(p0 + 120);
    checks++; if (n_short !== 1) begin failures++; $display("FAIL rst_after_short_count: got %0d want 1", n_short); end
    checks++; if (t_short !== p0 + 30 + 2 + REL + 1 + DBL) begin failures++; $display("FAIL rst_after_short_time: got %0d want %0d", t_short, p0 + 30 + 2 + REL + 1 + DBL); end
  endtask

  task automatic test_corner_press_timeout();
    int p0, r;
    clear_mon();
    press(p0);
    wait_until(p0 + 30);
    key_n = 1'b1;
    r = p0 + 30 + 2 + REL;
    wait_until(r + 30);
    key_n = 1'b0;
    wait_until(r + DBL);
    press_pulse = 1'b1;
    tick(1);
    press_pulse = 1'b0;
    wait_until(r + 50);
    key_n = 1'b1;
    wait_until(r + 100);
    checks++; if (n_double !== 1) begin failures++; $display("FAIL corner_dbl_count: got %0d want 1", n_double); end
    checks++; if (t_double !== r + 1 + DBL) begin failures++; $display("FAIL corner_dbl_time: got %0d want %0d", t_double, r + 1 + DBL); end
    checks++; if (n_short !== 0) begin failures++; $display("FAIL corner_dbl_no_short: got %0d want 0", n_short); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL corner_dbl_busy: got %b want 0", busy); end
  endtask

  task automatic test_corner_release_long();
    int p0;
    clear_mon();
    press(p0);
    // rel_ok first seen after edge p0+LONG-1, the long-press terminal count.
    wait_until(p0 + LONG - 1 - 2 - REL);
    key_n = 1'b1;
    wait_until(p0 + 160);
    checks++; if (n_long !== 0) begin failures++; $display("FAIL corner_rel_no_long: got %0d want 0", n_long); end
    checks++; if (n_short !== 1) begin failures++; $display("FAIL corner_rel_short_count: got %0d want 1", n_short); end
    checks++; if (t_short !== p0 + LONG + DBL) begin failures++; $display("FAIL corner_rel_short_time: got %0d want %0d", t_short, p0 + LONG + DBL); end
    checks++; if (n_repeat + n_double !== 0) begin failures++; $display("FAIL corner_rel_other: got %0d want 0", n_repeat + n_double); end
  endtask

  task automatic test_exclusive();
    checks++; if (n_multi !== 0) begin failures++; $display("FAIL exclusive_strobes: got %0d want 0", n_multi); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_short();
    test_double();
    test_long();
    test_glitch();
    test_reset_mid();
    test_corner_press_timeout();
    test_corner_release_long();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
